// File: rtl/fetch_datapath_if.sv
// Signal bundle between the fetch controller/memory side and the fetch datapath.
// master = controller + instruction memory, slave = datapath.
interface fetch_datapath_if;
   logic        pc_out;
   logic        pc_in;
   logic        inc_pc;
   logic        mar_in;
   logic        mar_rd;
   logic        ir_in;
   logic [7:0]  bus_in;
   logic [15:0] mem_rdata;
   logic        mem_rvalid;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic [3:0]  opcode;
   logic [3:0]  rd;
   logic [7:0]  imm;
   logic        instr_valid;
   logic        mbr_full;
   logic        busy;
   logic        err;

   modport master (
      output pc_out, pc_in, inc_pc, mar_in, mar_rd, ir_in, bus_in, mem_rdata, mem_rvalid,
      input  mem_addr, mem_rd, pc, ir, opcode, rd, imm, instr_valid, mbr_full, busy, err
   );

   modport slave (
      input  pc_out, pc_in, inc_pc, mar_in, mar_rd, ir_in, bus_in, mem_rdata, mem_rvalid,
      output mem_addr, mem_rd, pc, ir, opcode, rd, imm, instr_valid, mbr_full, busy, err
   );
endinterface

// File: rtl/fetch_datapath.sv
// Instruction fetch datapath: PC, MAR, MBR and IR with a three-state read
// sequencer (IDLE/WAIT/FULL), read timeout and a sticky protocol error flag.
module fetch_datapath (
   input  logic              clk,
   input  logic              reset,
   fetch_datapath_if.slave   fif
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_FULL = 2'd2;

   localparam logic [2:0] WAIT_LAST = 3'd7;

   logic [1:0]  state_reg,       state_next;
   logic [2:0]  wait_cnt_reg,    wait_cnt_next;
   logic [7:0]  pc_reg,          pc_next;
   logic [7:0]  mar_reg,         mar_next;
   logic [15:0] mbr_reg,         mbr_next;
   logic [15:0] ir_reg,          ir_next;
   logic        mem_rd_reg,      mem_rd_next;
   logic        instr_valid_reg, instr_valid_next;
   logic        err_reg,         err_next;
   logic        mar_err;
   logic        seq_err;

   // PC: an explicit load wins over increment; 8-bit add wraps naturally.
   always_comb begin
      pc_next = pc_reg;
      if (fif.pc_in)
         pc_next = fif.bus_in;
      else if (fif.inc_pc)
         pc_next = pc_reg + 8'd1;
   end

   // MAR samples the pre-update PC and stays frozen while a read is in flight.
   always_comb begin
      mar_next = mar_reg;
      mar_err  = 1'b0;
      if (fif.mar_in) begin
         if (state_reg == ST_WAIT)
            mar_err = 1'b1;
         else
            mar_next = fif.pc_out ? pc_reg : fif.bus_in;
      end
   end

   always_comb begin
      state_next       = state_reg;
      wait_cnt_next    = wait_cnt_reg;
      mbr_next         = mbr_reg;
      ir_next          = ir_reg;
      mem_rd_next      = 1'b0;
      instr_valid_next = 1'b0;
      seq_err          = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (fif.ir_in)
               seq_err = 1'b1;
            if (fif.mar_rd) begin
               mem_rd_next   = 1'b1;
               wait_cnt_next = 3'd0;
               state_next    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (fif.mar_rd || fif.ir_in)
               seq_err = 1'b1;
            if (fif.mem_rvalid) begin
               mbr_next   = fif.mem_rdata;
               state_next = ST_FULL;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               seq_err    = 1'b1;
               state_next = ST_IDLE;
            end else begin
               wait_cnt_next = wait_cnt_reg + 3'd1;
            end
         end
         ST_FULL: begin
            if (fif.ir_in) begin
               ir_next          = mbr_reg;
               instr_valid_next = 1'b1;
               // Back-to-back fetch: consume the word and launch the next read together.
               if (fif.mar_rd) begin
                  mem_rd_next   = 1'b1;
                  wait_cnt_next = 3'd0;
                  state_next    = ST_WAIT;
               end else begin
                  state_next = ST_IDLE;
               end
            end else if (fif.mar_rd) begin
               seq_err = 1'b1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
      err_next = err_reg | seq_err | mar_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= ST_IDLE;
         wait_cnt_reg    <= 3'd0;
         pc_reg          <= 8'h00;
         mar_reg         <= 8'h00;
         mbr_reg         <= 16'h0000;
         ir_reg          <= 16'h0000;
         mem_rd_reg      <= 1'b0;
         instr_valid_reg <= 1'b0;
         err_reg         <= 1'b0;
      end else begin
         state_reg       <= state_next;
         wait_cnt_reg    <= wait_cnt_next;
         pc_reg          <= pc_next;
         mar_reg         <= mar_next;
         mbr_reg         <= mbr_next;
         ir_reg          <= ir_next;
         mem_rd_reg      <= mem_rd_next;
         instr_valid_reg <= instr_valid_next;
         err_reg         <= err_next;
      end
   end

   assign fif.mem_addr    = mar_reg;
   assign fif.mem_rd      = mem_rd_reg;
   assign fif.pc          = pc_reg;
   assign fif.ir          = ir_reg;
   assign fif.opcode      = ir_reg[15:12];
   assign fif.rd          = ir_reg[11:8];
   assign fif.imm         = ir_reg[7:0];
   assign fif.instr_valid = instr_valid_reg;
   assign fif.mbr_full    = (state_reg == ST_FULL);
   assign fif.busy        = (state_reg == ST_WAIT);
   assign fif.err         = err_reg;
endmodule

// File: tb/tb_fetch_datapath.sv
// Directed, table-driven bench for fetch_datapath: one vector per clock cycle,
// outputs compared one time unit after the rising edge.
module tb_fetch_datapath;
   localparam logic [5:0] PO  = 6'b100000;
   localparam logic [5:0] PI  = 6'b010000;
   localparam logic [5:0] INC = 6'b001000;
   localparam logic [5:0] MI  = 6'b000100;
   localparam logic [5:0] MR  = 6'b000010;
   localparam logic [5:0] II  = 6'b000001;
   localparam logic [5:0] NO  = 6'b000000;

   typedef struct {
      logic        rst;
      logic [5:0]  s;
      logic [7:0]  bus;
      logic        rv;
      logic [15:0] rdata;
      logic [7:0]  e_pc;
      logic [7:0]  e_addr;
      logic        e_mrd;
      logic        e_busy;
      logic        e_full;
      logic [15:0] e_ir;
      logic        e_iv;
      logic        e_err;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   vec_t vecs[$];

   fetch_datapath_if fif();

   fetch_datapath dut (
      .clk   (clk),
      .reset (reset),
      .fif   (fif)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(logic rst, logic [5:0] s, logic [7:0] bus, logic rv,
                               logic [15:0] rdata, logic [7:0] e_pc, logic [7:0] e_addr,
                               logic e_mrd, logic e_busy, logic e_full, logic [15:0] e_ir,
                               logic e_iv, logic e_err);
      vec_t v;
      v.rst = rst;  v.s = s;  v.bus = bus;  v.rv = rv;  v.rdata = rdata;
      v.e_pc = e_pc;  v.e_addr = e_addr;  v.e_mrd = e_mrd;  v.e_busy = e_busy;
      v.e_full = e_full;  v.e_ir = e_ir;  v.e_iv = e_iv;  v.e_err = e_err;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Drive one cycle of stimulus, then compare the full visible state after the edge.
   task automatic apply(input string name, input vec_t v);
      @(negedge clk);
      reset          = v.rst;
      fif.pc_out     = v.s[5];
      fif.pc_in      = v.s[4];
      fif.inc_pc     = v.s[3];
      fif.mar_in     = v.s[2];
      fif.mar_rd     = v.s[1];
      fif.ir_in      = v.s[0];
      fif.bus_in     = v.bus;
      fif.mem_rvalid = v.rv;
      fif.mem_rdata  = v.rdata;
      @(posedge clk);
      #1;
      check(name,
            {27'd0, fif.pc, fif.mem_addr, fif.mem_rd, fif.busy, fif.mbr_full, fif.ir,
             fif.instr_valid, fif.err},
            {27'd0, v.e_pc, v.e_addr, v.e_mrd, v.e_busy, v.e_full, v.e_ir, v.e_iv, v.e_err});
   endtask

   initial begin
      reset = 1'b1;
      fif.pc_out = 1'b0; fif.pc_in = 1'b0; fif.inc_pc = 1'b0; fif.mar_in = 1'b0;
      fif.mar_rd = 1'b0; fif.ir_in = 1'b0; fif.bus_in = 8'h00;
      fif.mem_rvalid = 1'b0; fif.mem_rdata = 16'h0000;

      //             rst s        bus    rv rdata     pc     addr  mrd bsy ful ir        iv err
      vecs.push_back(mk(1, NO,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, PO|MI,   8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, MR,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, NO,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, NO,      8'h00, 1, 16'h3A05, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0));
      vecs.push_back(mk(0, II,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h3A05, 1, 0));
      vecs.push_back(mk(0, NO,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, PI,      8'hFE, 0, 16'h0000, 8'hFE, 8'h00, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, INC,     8'h00, 0, 16'h0000, 8'hFF, 8'h00, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, INC,     8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, PI|INC,  8'h10, 0, 16'h0000, 8'h10, 8'h00, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, MI,      8'h42, 0, 16'h0000, 8'h10, 8'h42, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, PO|MI|INC, 8'h00, 0, 16'h0000, 8'h11, 8'h10, 0, 0, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, MR,      8'h00, 0, 16'h0000, 8'h11, 8'h10, 1, 1, 0, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, NO,      8'h00, 1, 16'h1111, 8'h11, 8'h10, 0, 0, 1, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, NO,      8'h00, 1, 16'h2222, 8'h11, 8'h10, 0, 0, 1, 16'h3A05, 0, 0));
      vecs.push_back(mk(0, II,      8'h00, 0, 16'h0000, 8'h11, 8'h10, 0, 0, 0, 16'h1111, 1, 0));
      vecs.push_back(mk(0, NO,      8'h00, 0, 16'h0000, 8'h11, 8'h10, 0, 0, 0, 16'h1111, 0, 0));
      vecs.push_back(mk(0, MR,      8'h00, 0, 16'h0000, 8'h11, 8'h10, 1, 1, 0, 16'h1111, 0, 0));
      vecs.push_back(mk(0, NO,      8'h00, 1, 16'h5A5A, 8'h11, 8'h10, 0, 0, 1, 16'h1111, 0, 0));
      vecs.push_back(mk(0, II|MR,   8'h00, 0, 16'h0000, 8'h11, 8'h10, 1, 1, 0, 16'h5A5A, 1, 0));
      vecs.push_back(mk(0, NO,      8'h00, 1, 16'h1234, 8'h11, 8'h10, 0, 0, 1, 16'h5A5A, 0, 0));
      vecs.push_back(mk(0, II,      8'h00, 0, 16'h0000, 8'h11, 8'h10, 0, 0, 0, 16'h1234, 1, 0));
      vecs.push_back(mk(0, II,      8'h00, 0, 16'h0000, 8'h11, 8'h10, 0, 0, 0, 16'h1234, 0, 1));
      vecs.push_back(mk(1, NO,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, MR,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 16'h0000, 0, 0));
      vecs.push_back(mk(0, MR,      8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, MI,      8'h77, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, II,      8'h00, 1, 16'hABCD, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 1));
      vecs.push_back(mk(1, PO|PI|INC|MI|MR|II, 8'h55, 1, 16'hFFFF,
                                    8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));

      foreach (vecs[i])
         apply($sformatf("vec%0d", i), vecs[i]);

      // Fetch again and check the decoded IR fields.
      apply("fetch_mar", mk(0, PO|MI, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      apply("fetch_rd",  mk(0, MR,    8'h00, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 16'h0000, 0, 0));
      apply("fetch_rv",  mk(0, NO,    8'h00, 1, 16'h3A05, 8'h00, 8'h00, 0, 0, 1, 16'h0000, 0, 0));
      apply("fetch_ir",  mk(0, II,    8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h3A05, 1, 0));
      check("opcode", {60'd0, fif.opcode}, 64'h3);
      check("rd",     {60'd0, fif.rd},     64'hA);
      check("imm",    {56'd0, fif.imm},    64'h05);

      // Timeout: 8 WAIT cycles without rvalid, then back to IDLE with err set.
      apply("to_start", mk(0, MR, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 16'h3A05, 0, 0));
      for (int k = 1; k < 8; k++)
         apply($sformatf("to_wait%0d", k),
               mk(0, NO, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 1, 0, 16'h3A05, 0, 0));
      apply("to_expire", mk(0, NO, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h3A05, 0, 1));
      apply("rv_idle",   mk(0, NO, 8'h00, 1, 16'h9999, 8'h00, 8'h00, 0, 0, 0, 16'h3A05, 0, 1));

      // Reset mid-read: the late rvalid must not fill the MBR or raise err.
      apply("mr_reset0", mk(1, NO, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      apply("mr_read",   mk(0, MR, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 1, 1, 0, 16'h0000, 0, 0));
      apply("mr_reset1", mk(1, NO, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      apply("mr_late",   mk(0, NO, 8'h00, 1, 16'hBEEF, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 0));
      apply("mr_ir",     mk(0, II, 8'h00, 0, 16'h0000, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 0, 1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fetch_datapath.md
FETCH_DATAPATH -- requirements
Module: fetch_datapath

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 SHALL have port pc_out  input  1  controller strobe: drive PC onto internal address bus.
REQ-004 SHALL have port pc_in  input  1  controller strobe: load PC from bus_in.
REQ-005 SHALL have port inc_pc  input  1  controller strobe: PC increment.
REQ-006 SHALL have port mar_in  input  1  controller strobe: load MAR.
REQ-007 SHALL have port mar_rd  input  1  controller strobe (MAR_mramout): start instruction memory read at MAR.
REQ-008 SHALL have port ir_in  input  1  controller strobe: transfer MBR to IR.
REQ-009 SHALL have port bus_in  input  8  external address/jump target.
REQ-010 SHALL have port mem_rdata  input  16  instruction memory read data.
REQ-011 SHALL have port mem_rvalid  input  1  mem_rdata valid this cycle.
REQ-012 SHALL have port mem_addr  output  8  memory address, equals MAR.
REQ-013 SHALL have port mem_rd  output  1  one-cycle read request pulse.
REQ-014 SHALL have port pc  output  8  current PC.
REQ-015 SHALL have port ir  output  16  instruction register.
REQ-016 SHALL have port opcode  output  4  ir[15:12]; rd  output  4  ir[11:8]; imm  output  8  ir[7:0].
REQ-017 SHALL have port instr_valid  output  1  one-cycle pulse, IR loaded this cycle.
REQ-018 SHALL have port mbr_full  output  1  MBR holds an unconsumed word.
REQ-019 SHALL have port busy  output  1  read in flight (state WAIT).
REQ-020 SHALL have port err  output  1  sticky protocol/timeout error.

Function
REQ-021 FSM SHALL have states IDLE, WAIT, FULL; busy=1 only in WAIT, mbr_full=1 only in FULL.
REQ-022 PC update priority SHALL be: pc_in (PC<=bus_in) over inc_pc (PC<=PC+1, 8-bit, 0xFF wraps to 0x00); neither -> hold.
REQ-023 mar_in with pc_out SHALL load MAR<=PC (pre-update value); mar_in without pc_out SHALL load MAR<=bus_in.
REQ-024 mar_in in WAIT SHALL be ignored (MAR frozen during in-flight read) and set err.
REQ-025 mar_rd in IDLE SHALL assert mem_rd for exactly that next cycle with mem_addr=MAR and enter WAIT.
REQ-026 mar_rd in WAIT or FULL SHALL be ignored (no mem_rd) and set err; MBR contents preserved.
REQ-027 In WAIT, mem_rvalid SHALL capture mem_rdata into MBR and enter FULL next cycle.
REQ-028 mem_rvalid in IDLE or FULL SHALL be ignored (no MBR overwrite, no err).
REQ-029 WAIT SHALL time out after 8 cycles without mem_rvalid: return to IDLE, set err, MBR unchanged.
REQ-030 ir_in in FULL SHALL load IR<=MBR, pulse instr_valid one cycle, return to IDLE.
REQ-031 ir_in in IDLE or WAIT SHALL leave IR unchanged, no instr_valid, set err (underrun); includes same cycle as mem_rvalid.
REQ-032 ir_in and mar_rd both asserted in FULL SHALL perform IR load and issue new read next cycle (FULL->WAIT), no err.
REQ-033 IR SHALL hold its value until the next valid ir_in; opcode/rd/imm combinationally derived from IR.
REQ-034 err SHALL clear only on reset.

Reset
REQ-035 On reset: PC=0x00, MAR=0x00, MBR=0x0000, IR=0x0000, state IDLE, mem_rd=0, instr_valid=0, busy=0, mbr_full=0, err=0.
REQ-036 Reset mid-read SHALL abort to IDLE; a mem_rvalid arriving after reset SHALL be ignored.
REQ-037 Reset SHALL override all strobes in the same cycle.

Verification
REQ-038 Fetch: reset, pc_out+mar_in, mar_rd, rvalid data 0x3A05 after 2 cycles, ir_in -> mem_addr=0x00, mem_rd 1 cycle, IR=0x3A05, opcode=3, rd=A, imm=05, instr_valid 1 cycle, err=0.
REQ-039 PC: pc_in bus_in=0xFE, then inc_pc x2 -> PC 0xFE,0xFF,0x00; pc_in+inc_pc bus_in=0x10 -> PC=0x10.
REQ-040 Overwrite protection: FULL with MBR=0x1111, second rvalid 0x2222, then ir_in -> IR=0x1111, err=0.
REQ-041 Timeout: mar_rd, no rvalid for 8 cycles -> state IDLE, busy=0, err=1, IR unchanged.
REQ-042 Protocol errors: ir_in in IDLE -> err=1, no instr_valid; mar_rd in WAIT -> no second mem_rd, err=1.
REQ-043 Reset mid-read: mar_rd, reset next cycle, rvalid 0xBEEF after reset -> mbr_full=0, IR=0x0000.
